// File: rtl/seg7_readback_decoder_if.sv
// seg7_readback_decoder_if: segment buses toward the decoder, decoded value back
interface seg7_readback_decoder_if;
  logic [6:0] dig1;
  logic [6:0] dig2;
  logic [5:0] value;
  logic       valid;
  logic       error;
  modport master (output dig1, dig2, input value, valid, error);
  modport slave  (input dig1, dig2, output value, valid, error);
endinterface

// File: rtl/seg7_readback_decoder.sv
// seg7_readback_decoder: debounces a two-digit 7-seg pair and decodes it to a signed value
// Build option SEG_ACTIVE_LOW_EN: segment buses are active-low (common-anode)
module seg7_readback_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input logic                    clk,
  input logic                    rst,
  seg7_readback_decoder_if.slave bus
);
  typedef enum logic {SETTLE, LOCKED} state_t;
  state_t      r_state, w_state_nxt;
  logic [13:0] r_sample, w_pair;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [5:0]  r_value, w_mag, w_val;
  logic        r_valid, r_error, r_pub;
  logic        w_match, w_decode, w_legal, w_publish, w_ones_ok, w_tens_ok, w_neg;
  logic [3:0]  w_ones;
`ifdef SEG_ACTIVE_LOW_EN
  assign w_pair = ~{bus.dig1, bus.dig2};
`else
  assign w_pair = {bus.dig1, bus.dig2};
`endif
  assign w_match = w_pair == r_sample;
  always_comb begin
    w_ones_ok = 1'b1;
    w_ones    = 4'd0;
    case (w_pair[6:0])
      7'h3F: w_ones = 4'd0;
      7'h06: w_ones = 4'd1;
      7'h5B: w_ones = 4'd2;
      7'h4F: w_ones = 4'd3;
      7'h66: w_ones = 4'd4;
      7'h6D: w_ones = 4'd5;
      7'h7D: w_ones = 4'd6;
      7'h07: w_ones = 4'd7;
      7'h7F: w_ones = 4'd8;
      7'h6F: w_ones = 4'd9;
      default: w_ones_ok = 1'b0;
    endcase
  end
  assign w_neg     = w_pair[13:7] == 7'h40;
  assign w_tens_ok = w_pair[13:7] inside {7'h00, 7'h3F, 7'h06, 7'h40};
  assign w_mag     = (w_pair[13:7] == 7'h06 ? 6'd10 : 6'd0) + 6'(w_ones);
  assign w_val     = w_neg ? -w_mag : w_mag;
  // a lone minus sign in front of zero is not a glyph the encoder produces
  assign w_legal   = w_ones_ok && w_tens_ok && !(w_neg && w_ones == 4'd0);
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_decode    = 1'b0;
    if (!w_match) begin
      w_state_nxt = SETTLE;
      w_cnt_nxt   = '0;
    end else if (r_state == SETTLE) begin
      w_cnt_nxt = r_cnt + 8'd1;
      if (w_cnt_nxt == 8'(STABLE_CYCLES)) begin
        w_state_nxt = LOCKED;
        w_decode    = 1'b1;
      end
    end
  end
  assign w_publish = w_decode && w_legal && (w_val != r_value || !r_pub || r_error);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= SETTLE;
      r_cnt    <= '0;
      r_sample <= '0;
      r_value  <= '0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
      r_pub    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sample <= w_pair;
      r_valid  <= w_publish;
      if (w_publish) begin
        r_value <= w_val;
        r_pub   <= 1'b1;
      end
      if (w_decode) r_error <= !w_legal;
    end
  end
  assign bus.value = r_value;
  assign bus.valid = r_valid;
  assign bus.error = r_error;
endmodule
